// File: rtl/uart_app_ui_mc.sv
// Multi-channel UART application register bank: per-channel config, status, upload FSM, W1C events.
// Optional build macro UART_APP_IRQ_EN adds per-channel irq_en (offset 38) and a registered irq output.

module uart_app_ch #(
  parameter int BAUD_LIM_RST = 15337,
  parameter int BAUD_FRQ_RST = 288,
  parameter int WTD_RST      = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [31:0] wdata,
  input  logic [3:0]  rd_idx,
  output logic [31:0] rd_data,
  input  logic        tx_busy,
  input  logic        rx_busy,
  input  logic [31:0] tx_cnt,
  input  logic [31:0] rx_cnt,
  input  logic        upload_busy,
  input  logic        upload_done,
  input  logic [31:0] pkt_length,
  input  logic [31:0] pkt_cnt,
  output logic        wtd_en,
  output logic [31:0] wtd_preset,
  output logic [4:0]  tdest,
  output logic [15:0] baud_limit,
  output logic [11:0] baud_freq,
  output logic [3:0]  recv_parity,
  output logic        loopback_en,
  output logic        upload_req,
  output logic        irq_src
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} st_t;
  typedef struct packed {
    logic        wtd_en;
    logic [31:0] wtd_preset;
    logic [4:0]  tdest;
    logic [15:0] baud_limit;
    logic [11:0] baud_freq;
    logic [3:0]  recv_parity;
    logic        loopback_en;
  } cfg_t;

  localparam cfg_t CFG_RST = '{wtd_en: 1'b1, wtd_preset: 32'(WTD_RST), tdest: 5'd0,
                               baud_limit: 16'(BAUD_LIM_RST), baud_freq: 12'(BAUD_FRQ_RST),
                               recv_parity: 4'd0, loopback_en: 1'b0};

  st_t         state_q, state_d;
  cfg_t        cfg_q, cfg_d;
  logic [1:0]  sticky_q, sticky_d;
  logic [15:0] done_cnt_q, done_cnt_d;
  logic        upl_pend, wr_ctl, done_evt, ovr_evt;
`ifdef UART_APP_IRQ_EN
  logic [1:0]  irq_en_q, irq_en_d;
`endif

  assign upl_pend = (state_q != IDLE);
  assign wr_ctl   = wr_en && (wr_idx == 4'hB) && (wdata != 32'd0);
  assign done_evt = (state_q == WAIT) && upload_done;
  assign ovr_evt  = wr_ctl && upl_pend;

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    sticky_d   = sticky_q;
`ifdef UART_APP_IRQ_EN
    irq_en_d   = irq_en_q;
`endif
    case (state_q)
      IDLE:    if (wr_ctl) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (upload_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wr_en) begin
      case (wr_idx)
        4'h0: cfg_d.wtd_en      = wdata[0];
        4'h1: cfg_d.wtd_preset  = wdata;
        4'h2: cfg_d.tdest       = wdata[4:0];
        4'h3: cfg_d.baud_limit  = wdata[15:0];
        4'h4: cfg_d.baud_freq   = wdata[11:0];
        4'h5: cfg_d.recv_parity = wdata[3:0];
        4'hC: cfg_d.loopback_en = wdata[0];
        4'hD: sticky_d          = sticky_q & ~wdata[1:0];
`ifdef UART_APP_IRQ_EN
        4'hE: irq_en_d          = wdata[1:0];
`endif
        default: ;
      endcase
    end
    // set events are OR'd in after the clear so they win over a same-cycle W1C
    sticky_d   = sticky_d | {ovr_evt, done_evt};
    done_cnt_d = done_cnt_q + 16'(done_evt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cfg_q      <= CFG_RST;
      sticky_q   <= '0;
      done_cnt_q <= '0;
`ifdef UART_APP_IRQ_EN
      irq_en_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      sticky_q   <= sticky_d;
      done_cnt_q <= done_cnt_d;
`ifdef UART_APP_IRQ_EN
      irq_en_q   <= irq_en_d;
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_idx)
      4'h0: rd_data = 32'(cfg_q.wtd_en);
      4'h1: rd_data = cfg_q.wtd_preset;
      4'h2: rd_data = 32'(cfg_q.tdest);
      4'h3: rd_data = 32'(cfg_q.baud_limit);
      4'h4: rd_data = 32'(cfg_q.baud_freq);
      4'h5: rd_data = 32'(cfg_q.recv_parity);
      4'h6: rd_data = tx_cnt;
      4'h7: rd_data = rx_cnt;
      4'h8: rd_data = {28'd0, upl_pend, upload_busy, rx_busy, tx_busy};
      4'h9: rd_data = pkt_cnt;
      4'hA: rd_data = pkt_length;
      4'hB: rd_data = 32'(upl_pend);
      4'hC: rd_data = 32'(cfg_q.loopback_en);
      4'hD: rd_data = 32'(sticky_q);
`ifdef UART_APP_IRQ_EN
      4'hE: rd_data = 32'(irq_en_q);
`endif
      4'hF: rd_data = 32'(done_cnt_q);
      default: rd_data = '0;
    endcase
  end

  assign wtd_en      = cfg_q.wtd_en;
  assign wtd_preset  = cfg_q.wtd_preset;
  assign tdest       = cfg_q.tdest;
  assign baud_limit  = cfg_q.baud_limit;
  assign baud_freq   = cfg_q.baud_freq;
  assign recv_parity = cfg_q.recv_parity;
  assign loopback_en = cfg_q.loopback_en;
  assign upload_req  = (state_q == ISSUE);
`ifdef UART_APP_IRQ_EN
  assign irq_src     = |(sticky_q & irq_en_q);
`else
  assign irq_src     = 1'b0;
`endif
endmodule

module uart_app_ui_mc #(
  parameter int NUM_CH       = 2,
  parameter int ADDR_W       = 12,
  parameter int BAUD_LIM_RST = 15337,
  parameter int BAUD_FRQ_RST = 288,
  parameter int WTD_RST      = 320
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     app_axi_rreq,
  output logic                     app_axi_rack,
  input  logic [ADDR_W-1:0]        app_axi_raddr,
  output logic [31:0]              app_axi_rdata,
  input  logic                     app_axi_wreq,
  output logic                     app_axi_wack,
  input  logic [ADDR_W-1:0]        app_axi_waddr,
  input  logic [31:0]              app_axi_wdata,
  output logic [NUM_CH-1:0]        loopback_en,
  output logic [NUM_CH-1:0]        wtd_en,
  output logic [NUM_CH-1:0][4:0]   tdest,
  output logic [NUM_CH-1:0][11:0]  baud_freq,
  output logic [NUM_CH-1:0][15:0]  baud_limit,
  output logic [NUM_CH-1:0][3:0]   recv_parity,
  output logic [NUM_CH-1:0][31:0]  wtd_preset,
  input  logic [NUM_CH-1:0]        tx_busy,
  input  logic [NUM_CH-1:0]        rx_busy,
  input  logic [NUM_CH-1:0][31:0]  tx_cnt,
  input  logic [NUM_CH-1:0][31:0]  rx_cnt,
  output logic [NUM_CH-1:0]        upload_req,
  input  logic [NUM_CH-1:0]        upload_busy,
  input  logic [NUM_CH-1:0]        upload_done,
  input  logic [NUM_CH-1:0][31:0]  pkt_length,
  input  logic [NUM_CH-1:0][31:0]  pkt_cnt,
  output logic                     irq
);
  localparam int CH_W = ADDR_W - 6;

  logic [NUM_CH-1:0][31:0] ch_rd;
  logic [NUM_CH-1:0]       ch_wr, irq_src;
  logic [31:0]             rd_sel, rdata_d, rdata_q;
  logic                    rd_hit, rack_q, wack_q, irq_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_wr[c] = app_axi_wreq && (app_axi_waddr[1:0] == 2'b00) &&
                      (app_axi_waddr[ADDR_W-1:6] == CH_W'(c));
    uart_app_ch #(
      .BAUD_LIM_RST(BAUD_LIM_RST), .BAUD_FRQ_RST(BAUD_FRQ_RST), .WTD_RST(WTD_RST)
    ) u_ch (
      .clk(clk), .rst(rst),
      .wr_en(ch_wr[c]), .wr_idx(app_axi_waddr[5:2]), .wdata(app_axi_wdata),
      .rd_idx(app_axi_raddr[5:2]), .rd_data(ch_rd[c]),
      .tx_busy(tx_busy[c]), .rx_busy(rx_busy[c]), .tx_cnt(tx_cnt[c]), .rx_cnt(rx_cnt[c]),
      .upload_busy(upload_busy[c]), .upload_done(upload_done[c]),
      .pkt_length(pkt_length[c]), .pkt_cnt(pkt_cnt[c]),
      .wtd_en(wtd_en[c]), .wtd_preset(wtd_preset[c]), .tdest(tdest[c]),
      .baud_limit(baud_limit[c]), .baud_freq(baud_freq[c]), .recv_parity(recv_parity[c]),
      .loopback_en(loopback_en[c]), .upload_req(upload_req[c]), .irq_src(irq_src[c])
    );
  end

  // unmatched channel field falls through with rd_hit low -> DEADBEEF
  always_comb begin
    rd_hit = 1'b0;
    rd_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (app_axi_raddr[ADDR_W-1:6] == CH_W'(c)) begin
        rd_hit = 1'b1;
        rd_sel = ch_rd[c];
      end
    end
    rdata_d = '0;
    if (app_axi_rreq)
      rdata_d = (rd_hit && app_axi_raddr[1:0] == 2'b00) ? rd_sel : 32'hDEAD_BEEF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rack_q  <= 1'b0;
      wack_q  <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      rack_q  <= app_axi_rreq;
      wack_q  <= app_axi_wreq;
      rdata_q <= rdata_d;
      irq_q   <= |irq_src;
    end
  end

  assign app_axi_rack  = rack_q;
  assign app_axi_wack  = wack_q;
  assign app_axi_rdata = rdata_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_uart_app_ui_mc.sv
// Bench for uart_app_ui_mc: table-driven register accesses with a read scoreboard,
// plus hand sequences for upload, overrun, async reset and irq.
module tb_uart_app_ui_mc;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 12;
`ifdef UART_APP_IRQ_EN
  localparam logic [31:0] IRQ_RB = 32'd3;
`else
  localparam logic [31:0] IRQ_RB = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic rreq, rack, wreq, wack, irq;
  logic [ADDR_W-1:0] raddr, waddr;
  logic [31:0] rdata, wdata;
  logic [NUM_CH-1:0] loopback_en, wtd_en, tx_busy, rx_busy, upload_req, upload_busy, upload_done;
  logic [NUM_CH-1:0][4:0]  tdest;
  logic [NUM_CH-1:0][11:0] baud_freq;
  logic [NUM_CH-1:0][15:0] baud_limit;
  logic [NUM_CH-1:0][3:0]  recv_parity;
  logic [NUM_CH-1:0][31:0] wtd_preset, tx_cnt, rx_cnt, pkt_length, pkt_cnt;

  uart_app_ui_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .app_axi_rreq(rreq), .app_axi_rack(rack), .app_axi_raddr(raddr), .app_axi_rdata(rdata),
    .app_axi_wreq(wreq), .app_axi_wack(wack), .app_axi_waddr(waddr), .app_axi_wdata(wdata),
    .loopback_en(loopback_en), .wtd_en(wtd_en), .tdest(tdest), .baud_freq(baud_freq),
    .baud_limit(baud_limit), .recv_parity(recv_parity), .wtd_preset(wtd_preset),
    .tx_busy(tx_busy), .rx_busy(rx_busy), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
    .upload_req(upload_req), .upload_busy(upload_busy), .upload_done(upload_done),
    .pkt_length(pkt_length), .pkt_cnt(pkt_cnt), .irq(irq)
  );

  typedef struct { logic [11:0] addr; logic [31:0] exp; } sb_t;
  typedef struct { logic wr; logic [11:0] addr; logic [31:0] data; } vec_t;
  sb_t  exp_q[$];
  vec_t vt[$];
  sb_t  mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rack) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rack_unexpected: got rack=1 with rdata %0h expected no read", rdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("rd_%03h", mon_e.addr), 64'(rdata), 64'(mon_e.exp));
        end
      end else begin
        chk("rdata_idle", 64'(rdata), 64'd0);
      end
    end
  end

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); wreq = 1'b1; waddr = a; wdata = d;
    @(negedge clk); wreq = 1'b0;
    chk($sformatf("wack_%03h", a), 64'(wack), 64'd1);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e);
    sb_t s;
    @(negedge clk); rreq = 1'b1; raddr = a;
    s.addr = a; s.exp = e; exp_q.push_back(s);
    @(negedge clk); rreq = 1'b0;
  endtask

  task automatic done_pulse(input int c);
    @(negedge clk); upload_done[c] = 1'b1;
    @(negedge clk); upload_done[c] = 1'b0;
  endtask

  task automatic add(input logic w, input logic [11:0] a, input logic [31:0] d);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; vt.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rreq = 0; wreq = 0; raddr = '0; waddr = '0; wdata = '0;
    tx_busy = 2'b01; rx_busy = 2'b10; upload_busy = '0; upload_done = '0;
    tx_cnt = {32'h1111_2222, 32'hA5A5_0001};
    rx_cnt = {32'h0BAD_F00D, 32'h0000_0042};
    pkt_length = {32'd1500, 32'd64};
    pkt_cnt = {32'd7, 32'd3};

    // register table: wr=1 -> data is wdata, wr=0 -> data is expected read value
    add(0, 12'h00C, 32'h3BE9);       add(0, 12'h04C, 32'h3BE9);
    add(1, 12'h04C, 32'h0001_2345);  add(0, 12'h04C, 32'h2345);
    add(0, 12'h00C, 32'h3BE9);
    add(1, 12'h004, 32'hCAFE_F00D);  add(0, 12'h004, 32'hCAFE_F00D);
    add(0, 12'h044, 32'd320);
    add(1, 12'h008, 32'hFF);         add(0, 12'h008, 32'h1F);
    add(1, 12'h010, 32'hFFFF);       add(0, 12'h010, 32'hFFF);
    add(0, 12'h050, 32'd288);
    add(1, 12'h054, 32'h3A);         add(0, 12'h054, 32'hA);
    add(1, 12'h000, 32'hFFFF_FFFE);  add(0, 12'h000, 32'd0);
    add(0, 12'h040, 32'd1);
    add(1, 12'h070, 32'd1);          add(0, 12'h070, 32'd1);
    add(0, 12'h030, 32'd0);
    add(0, 12'h080, 32'hDEAD_BEEF);  add(0, 12'h002, 32'hDEAD_BEEF);
    add(0, 12'h0C0, 32'hDEAD_BEEF);  add(0, 12'h04E, 32'hDEAD_BEEF);
    add(1, 12'h080, 32'hFFFF_FFFF);  add(1, 12'h08C, 32'hFFFF);
    add(1, 12'h04E, 32'h7);          add(0, 12'h04C, 32'h2345);
    add(0, 12'h038, 32'd0);
    add(1, 12'h038, 32'd3);          add(0, 12'h038, IRQ_RB);
    add(1, 12'h038, 32'd0);
    add(0, 12'h018, 32'hA5A5_0001);  add(0, 12'h058, 32'h1111_2222);
    add(0, 12'h01C, 32'h42);         add(0, 12'h05C, 32'h0BAD_F00D);
    add(0, 12'h020, 32'h1);          add(0, 12'h060, 32'h2);
    add(0, 12'h024, 32'd3);          add(0, 12'h068, 32'd1500);
    add(0, 12'h028, 32'd64);         add(0, 12'h03C, 32'd0);
    add(0, 12'h07C, 32'd0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rack", 64'(rack), 64'd0);
    chk("rst_wack", 64'(wack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_upload_req", 64'(upload_req), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_wtd_en", 64'(wtd_en), 64'b11);
    chk("rst_wtd_preset", 64'(wtd_preset), {32'd320, 32'd320});
    chk("rst_baud_limit", 64'(baud_limit), 64'({16'd15337, 16'd15337}));
    chk("rst_baud_freq", 64'(baud_freq), 64'({12'd288, 12'd288}));
    chk("rst_tdest", 64'(tdest), 64'd0);
    chk("rst_parity", 64'(recv_parity), 64'd0);
    chk("rst_loopback", 64'(loopback_en), 64'd0);
    rst = 1'b0;

    foreach (vt[i]) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].data);
      else          rd(vt[i].addr, vt[i].data);
    end
    @(negedge clk);
    chk("out_baud_limit", 64'(baud_limit), 64'({16'h2345, 16'h3BE9}));
    chk("out_baud_freq", 64'(baud_freq), 64'({12'd288, 12'hFFF}));
    chk("out_tdest", 64'(tdest), 64'({5'd0, 5'h1F}));
    chk("out_parity", 64'(recv_parity), 64'({4'hA, 4'h0}));
    chk("out_wtd_en", 64'(wtd_en), 64'b10);
    chk("out_loopback", 64'(loopback_en), 64'b10);
    chk("out_wtd_preset", 64'(wtd_preset), {32'd320, 32'hCAFE_F00D});

    // upload handshake on ch0
    wr(12'h02C, 32'd1);
    chk("upl_req_issue", 64'(upload_req), 64'b01);
    @(negedge clk);
    chk("upl_req_wait", 64'(upload_req), 64'd0);
    upload_busy[0] = 1'b1;
    rd(12'h020, 32'hD);
    rd(12'h02C, 32'd1);
    upload_busy[0] = 1'b0;
    done_pulse(0);
    rd(12'h034, 32'd1); rd(12'h03C, 32'd1); rd(12'h02C, 32'd0);
    done_pulse(0);
    rd(12'h03C, 32'd1);
    wr(12'h02C, 32'd0);
    chk("upl_req_zero", 64'(upload_req), 64'd0);
    rd(12'h02C, 32'd0);

    // overrun, done during ISSUE ignored, W1C racing a set event
    wr(12'h034, 32'd1);
    rd(12'h034, 32'd0);
    wr(12'h02C, 32'd1);
    chk("upl_req_issue2", 64'(upload_req), 64'b01);
    upload_done[0] = 1'b1;
    @(negedge clk); upload_done[0] = 1'b0;
    rd(12'h03C, 32'd1); rd(12'h02C, 32'd1);
    wr(12'h02C, 32'd5);
    chk("upl_req_ovr", 64'(upload_req), 64'd0);
    rd(12'h034, 32'd2);
    @(negedge clk); wreq = 1'b1; waddr = 12'h034; wdata = 32'd3; upload_done[0] = 1'b1;
    @(negedge clk); wreq = 1'b0; upload_done[0] = 1'b0;
    rd(12'h034, 32'd1); rd(12'h03C, 32'd2); rd(12'h02C, 32'd0);

    // async reset in the middle of WAIT
    wr(12'h02C, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_upload_req", 64'(upload_req), 64'd0);
    chk("arst_baud_limit", 64'(baud_limit), 64'({16'd15337, 16'd15337}));
    chk("arst_wtd_preset", 64'(wtd_preset), {32'd320, 32'd320});
    chk("arst_wack", 64'(wack), 64'd0);
    @(negedge clk); rst = 1'b0;
    rd(12'h04C, 32'h3BE9); rd(12'h02C, 32'd0); rd(12'h03C, 32'd0); rd(12'h034, 32'd0);

    // irq from ch1 done event
    wr(12'h078, 32'd1);
    wr(12'h06C, 32'd1);
    chk("upl_req_ch1", 64'(upload_req), 64'b10);
    done_pulse(1);
    chk("irq_lat0", 64'(irq), 64'd0);
    @(negedge clk);
`ifdef UART_APP_IRQ_EN
    chk("irq_set", 64'(irq), 64'd1);
    rd(12'h074, 32'd1);
    wr(12'h074, 32'd1);
    @(negedge clk);
    chk("irq_clr", 64'(irq), 64'd0);
`else
    chk("irq_tied", 64'(irq), 64'd0);
    rd(12'h074, 32'd1);
    rd(12'h078, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
